display_buf_reader: RTL and testbench
=====================================

DISPLAY_BUF_READER -- requirements
Module: display_buf_reader

Interface
REQ-001 Parameter X_MAX, default 160, pixels per row.
REQ-002 Parameter Y_MAX, default 80, rows per frame.
REQ-003 Parameter WIDTH, default 8, RAM pixel width (RGB332).
REQ-004 Parameter RD_LAT, default 2, RAM read latency in cycles (addr to dout).
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 start  in  1  single-cycle request to stream one frame.
REQ-008 busy  out  1  high from accepted start until frame_done.
REQ-009 frame_done  out  1  one-cycle pulse after the last pixel handshake.
REQ-010 addr  out  ceil(log2(X_MAX*Y_MAX))  display buffer read address.
REQ-011 dout  in  WIDTH  display buffer read data.
REQ-012 pix_data  out  16  pixel to LCD transmitter.
REQ-013 pix_valid  out  1  pix_data/pix_sof/pix_eol valid.
REQ-014 pix_ready  in  1  LCD transmitter accepts the pixel when high with pix_valid.
REQ-015 pix_sof  out  1  marks pixel (0,0).
REQ-016 pix_eol  out  1  marks pixel x = X_MAX-1 of every row.

Function
REQ-017 Reads the buffer row-major, addr = y*X_MAX + x, from 0 to X_MAX*Y_MAX-1, once per accepted start.
REQ-018 FSM states IDLE, FETCH, DRAIN, DONE; IDLE->FETCH on start; FETCH->DRAIN after last address issued; DRAIN->DONE when last pixel handshakes; DONE->IDLE after one cycle (frame_done high in DONE).
REQ-019 start is ignored when busy is high.
REQ-020 A read issued in cycle t is captured from dout in cycle t+RD_LAT into a 4-entry output FIFO.
REQ-021 A new read is issued only if FIFO occupancy plus reads in flight < 4; the FIFO never overflows and never drops data.
REQ-022 With pix_ready held high, sustained throughput is one pixel per cycle after the first pixel appears RD_LAT+1 cycles after start.
REQ-023 pix_valid/pix_data/pix_sof/pix_eol are held stable while pix_valid is high and pix_ready is low.
REQ-024 Handshake completes only when pix_valid and pix_ready are both high; pix_ready low stalls address issue per REQ-021 without losing position.
REQ-025 Sideband flags travel through the FIFO with their pixel; the final pixel carries pix_eol.
REQ-026 Exactly X_MAX*Y_MAX handshakes occur per frame; frame_done pulses the cycle after the last one.
REQ-027 A start arriving in the DONE cycle is ignored; a start arriving in IDLE the following cycle is accepted.

Reset
REQ-028 On rst_n low: FSM to IDLE, counters to 0, FIFO and in-flight tracking flushed, busy, frame_done, pix_valid, pix_sof, pix_eol = 0, addr = 0, pix_data = 0.
REQ-029 Reset mid-frame abandons the frame; no frame_done is generated; read data returning after reset is discarded.

Configuration
REQ-030 Macro DISPLAY_BUF_READER_RGB565_EN defined: pix_data = RGB565 expansion of RGB332, R5={r[2:0],r[2:1]}, G6={g[2:0],g[2:0]}, B5={b[1:0],b[1:0],b[1]}.
REQ-031 Macro undefined: pix_data = {8'h00, dout byte} unchanged; no conversion logic is synthesized.

Structure
REQ-032 Shared package display_pkg holds X_MAX/Y_MAX defaults, buffer length, the RGB332-to-RGB565 conversion function, and the FSM state typedef.
REQ-033 Output FIFO is a separate sub-module pix_fifo (depth 4, width 18: data plus sof/eol, count output).

Verification
REQ-034 Buffer filled with addr[7:0], pix_ready always 1, start pulse -> 12800 pixels in order 0x00..0xFF repeating, first at cycle start+3, frame_done one cycle after last.
REQ-035 pix_ready random 30% duty -> identical pixel sequence, no gaps or duplicates, data stable during stalls, FIFO count never exceeds 4.
REQ-036 Flags check -> pix_sof only on pixel 0; pix_eol on pixels 159, 319, ..., 12799 (80 total).
REQ-037 RGB565_EN defined, pixel 0xE0 -> pix_data 0xF800; 0x1C -> 0x07E0; 0x03 -> 0x001F; 0xFF -> 0xFFFF; undefined, 0xE0 -> 0x00E0.
REQ-038 rst_n low at pixel 5000 with reads in flight, then start -> no frame_done for aborted frame, new frame begins at addr 0 with pix_sof on first pixel.
REQ-039 start pulsed during busy and in DONE cycle -> ignored, exactly one frame of 12800 pixels streamed.

Source files
------------

// File: rtl/display_pkg.sv
// Shared display-path definitions: frame geometry defaults, reader FSM states
// and the RGB332-to-RGB565 pixel expansion.
package display_pkg;

  localparam int X_MAX_DEF = 160;
  localparam int Y_MAX_DEF = 80;
  localparam int BUF_LEN   = X_MAX_DEF * Y_MAX_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  // Replicate the high bits into the low bits so full-scale maps to full-scale.
  function automatic logic [15:0] rgb332_to_565(input logic [7:0] p);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = p[7:5];
    g = p[4:2];
    b = p[1:0];
    return {r, r[2:1], g, g, b, b, b[1]};
  endfunction

endpackage

// File: rtl/pix_fifo.sv
// Small pixel FIFO (data plus sof/eol sidebands) with a combinational head
// read and an occupancy count used for read-issue credit.
module pix_fifo #(
  parameter int  DEPTH = 4,
  parameter int  W     = 18,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_dat_i,
  input  logic          rd_en_i,
  output logic [W-1:0]  rd_dat_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          full;
  logic          wr_ok;
  logic          rd_ok;

  assign empty_o  = (cnt_q == '0);
  assign full     = (cnt_q == CW'(DEPTH));
  assign rd_ok    = rd_en_i && !empty_o;
  assign wr_ok    = wr_en_i && (!full || rd_ok);
  assign rd_dat_o = mem_q[rd_ptr_q];
  assign count_o  = cnt_q;

  // Storage is cleared too so the head reads as zero straight out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_ok) begin
        mem_q[wr_ptr_q] <= wr_dat_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      cnt_q <= cnt_q + CW'(wr_ok) - CW'(rd_ok);
    end
  end

endmodule

// File: rtl/display_buf_reader.sv
// Streams one frame from the display buffer to the LCD pixel interface, row-major.
// Define DISPLAY_BUF_READER_RGB565_EN to expand RGB332 pixels to RGB565.
module display_buf_reader
  import display_pkg::*;
#(
  parameter int  X_MAX  = X_MAX_DEF,
  parameter int  Y_MAX  = Y_MAX_DEF,
  parameter int  WIDTH  = 8,
  parameter int  RD_LAT = 2,
  localparam int NPIX   = X_MAX * Y_MAX,
  localparam int ADDR_W = (NPIX > 1) ? $clog2(NPIX) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  dout,
  output logic [15:0]       pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol
);

  localparam int XW         = (X_MAX > 1) ? $clog2(X_MAX) : 1;
  localparam int FIFO_DEPTH = 4;
  localparam int CW         = 3;

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XW-1:0]     x_q, x_d;
  logic [ADDR_W-1:0] hs_cnt_q, hs_cnt_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [RD_LAT-1:0] pipe_vld_q, pipe_sof_q, pipe_eol_q;

  logic [CW-1:0]     fifo_cnt;
  logic              fifo_empty;
  logic [17:0]       fifo_head;
  logic [17:0]       fifo_wdat;
  logic [7:0]        pix8;
  logic [15:0]       pix_conv;

  logic              issue;
  logic              credit_ok;
  logic              at_last_addr;
  logic              at_first_addr;
  logic              at_eol_x;
  logic              cap_vld;
  logic              hs;
  logic              hs_last;

  // Read data already in flight is counted against the FIFO so it always has a slot.
  assign credit_ok     = ({1'b0, fifo_cnt} + {1'b0, inflight_q}) < 4'(FIFO_DEPTH);
  assign at_last_addr  = (addr_q == ADDR_W'(NPIX - 1));
  assign at_first_addr = (addr_q == '0);
  assign at_eol_x      = (x_q == XW'(X_MAX - 1));
  assign cap_vld       = pipe_vld_q[RD_LAT-1];
  assign hs            = pix_valid && pix_ready;
  assign hs_last       = hs && (hs_cnt_q == ADDR_W'(NPIX - 1));

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      // addr sits at 0 while idle, so the first read goes out in the start cycle.
      IDLE: begin
        if (start) begin
          issue   = 1'b1;
          state_d = at_last_addr ? DRAIN : FETCH;
        end
      end
      FETCH: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (at_last_addr) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (hs_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    x_d        = x_q;
    hs_cnt_d   = hs_cnt_q;
    inflight_d = inflight_q + CW'(issue) - CW'(cap_vld);
    if (issue) begin
      addr_d = at_last_addr ? '0 : addr_q + 1'b1;
      x_d    = at_eol_x ? '0 : x_q + 1'b1;
    end
    if (hs) begin
      hs_cnt_d = hs_last ? '0 : hs_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      x_q        <= '0;
      hs_cnt_q   <= '0;
      inflight_q <= '0;
      pipe_vld_q <= '0;
      pipe_sof_q <= '0;
      pipe_eol_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      x_q        <= x_d;
      hs_cnt_q   <= hs_cnt_d;
      inflight_q <= inflight_d;
      // Stage RD_LAT-1 lines up with the cycle the buffer presents the data.
      pipe_vld_q <= RD_LAT'({pipe_vld_q, issue});
      pipe_sof_q <= RD_LAT'({pipe_sof_q, issue && at_first_addr});
      pipe_eol_q <= RD_LAT'({pipe_eol_q, issue && at_eol_x});
    end
  end

  assign pix8 = 8'(dout);

`ifdef DISPLAY_BUF_READER_RGB565_EN
  assign pix_conv = rgb332_to_565(pix8);
`else
  assign pix_conv = {8'h00, pix8};
`endif

  assign fifo_wdat = {pipe_sof_q[RD_LAT-1], pipe_eol_q[RD_LAT-1], pix_conv};

  pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (18)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en_i  (cap_vld),
    .wr_dat_i (fifo_wdat),
    .rd_en_i  (hs),
    .rd_dat_o (fifo_head),
    .count_o  (fifo_cnt),
    .empty_o  (fifo_empty)
  );

  assign pix_valid  = !fifo_empty;
  assign pix_data   = fifo_head[15:0];
  assign pix_sof    = pix_valid && fifo_head[17];
  assign pix_eol    = pix_valid && fifo_head[16];
  assign addr       = addr_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_display_buf_reader.sv
// Bench for display_buf_reader: a two-cycle buffer model feeds the reader and every
// accepted pixel is compared with the row-major frame expected from buffer contents.
`timescale 1ns/1ps
module tb_display_buf_reader;

  localparam int XM   = 160;
  localparam int YM   = 80;
  localparam int NPIX = XM * YM;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        pix_ready = 1'b0;
  logic        busy, frame_done, pix_valid, pix_sof, pix_eol;
  logic [13:0] addr;
  logic [7:0]  dout;
  logic [15:0] pix_data;

  logic [7:0]  mem [NPIX];
  logic [15:0] got [NPIX];
  logic [13:0] addr_d1;
  int          n_checks = 0;
  int          n_err = 0;

  display_buf_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .addr       (addr),
    .dout       (dout),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol)
  );

  always #5 clk = ~clk;

  // Buffer: address presented in cycle t appears on dout in cycle t+2.
  always @(posedge clk) begin
    addr_d1 <= addr;
    dout    <= mem[addr_d1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] expand(input logic [7:0] b);
`ifdef DISPLAY_BUF_READER_RGB565_EN
    int r  = int'(b) >> 5;
    int g  = (int'(b) >> 2) & 7;
    int bl = int'(b) & 3;
    int r5 = (r << 2) | (r >> 1);
    int g6 = (g << 3) | g;
    int b5 = (bl << 3) | (bl << 1) | (bl >> 1);
    return 16'((r5 << 11) | (g6 << 5) | b5);
`else
    return {8'h00, b};
`endif
  endfunction

  // Called at a negedge; starts a frame and consumes it with the given ready duty.
  task automatic stream_frame(input int ready_pct, input int poke_idx, input int abort_idx);
    int          idx = 0;
    int          cyc = 0;
    int          first_cyc = -1;
    int          last_hs = -10;
    int          eols = 0;
    bit          stalled = 1'b0;
    bit          done = 1'b0;
    bit          aborted = 1'b0;
    logic [18:0] held = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check("busy_after_start", 32'(busy), 32'd1);
    while (!done && !aborted && cyc < 60000) begin
      if (pix_valid && first_cyc < 0) begin
        first_cyc = cyc;
        check("first_pixel_latency", first_cyc, 32'd3);
      end
      if (stalled) check("stall_hold", {pix_valid, pix_sof, pix_eol, pix_data}, held);
      check("fifo_count_max", 32'(dut.u_fifo.count_o <= 4), 32'd1);
      if (frame_done) begin
        check("done_pixel_count", idx, NPIX);
        check("done_after_last", cyc, last_hs + 1);
        check("eol_total", eols, YM);
        done = 1'b1;
      end else begin
        start = (idx == poke_idx);
        pix_ready = ($urandom_range(99) < ready_pct);
        if (pix_valid && pix_ready) begin
          check("pixel", {pix_data, pix_sof, pix_eol},
                {expand(mem[idx]), idx == 0, (idx % XM) == XM - 1});
          got[idx] = pix_data;
          if (pix_eol) eols++;
          idx++;
          last_hs = cyc;
          if (idx == abort_idx) aborted = 1'b1;
        end
        stalled = pix_valid && !pix_ready;
        held = {pix_valid, pix_sof, pix_eol, pix_data};
        if (!aborted) begin
          @(negedge clk);
          cyc++;
        end
      end
    end
    start = 1'b0;
    if (!done && !aborted) check("frame_timeout", 32'd0, 32'd1);
    if (aborted) begin
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_valid", 32'(pix_valid), 32'd0);
      check("abort_addr", 32'(addr), 32'd0);
      check("abort_data", 32'(pix_data), 32'd0);
      rst_n = 1'b1;
      repeat (12) begin
        @(negedge clk);
        check("abort_no_done", 32'(frame_done), 32'd0);
        check("abort_no_stale", 32'(pix_valid), 32'd0);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) mem[i] = 8'(i);
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_valid", 32'(pix_valid), 32'd0);
    check("rst_sof", 32'(pix_sof), 32'd0);
    check("rst_eol", 32'(pix_eol), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_data", 32'(pix_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Frame A: counting pattern, always ready, start poked mid-frame.
    stream_frame(100, 100, -1);
`ifdef DISPLAY_BUF_READER_RGB565_EN
    check("rgb_e0", 32'(got[8'hE0]), 32'hF800);
    check("rgb_1c", 32'(got[8'h1C]), 32'h07E0);
    check("rgb_03", 32'(got[8'h03]), 32'h001F);
    check("rgb_ff", 32'(got[8'hFF]), 32'hFFFF);
`else
    check("raw_e0", 32'(got[8'hE0]), 32'h00E0);
    check("raw_ff", 32'(got[8'hFF]), 32'h00FF);
`endif
    // Start during the DONE cycle must be ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_start_ignored", 32'(busy), 32'd0);
    check("done_single_pulse", 32'(frame_done), 32'd0);

    // Frame B: random contents, 30% ready, started in the first IDLE cycle.
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    stream_frame(30, 6000, -1);
    repeat (20) begin
      @(negedge clk);
      check("no_extra_frame_valid", 32'(pix_valid), 32'd0);
      check("no_extra_frame_busy", 32'(busy), 32'd0);
    end

    // Frame C aborted by reset, then frame D must restart from pixel 0.
    for (int i = 0; i < NPIX; i++) mem[i] = 8'(i);
    pix_ready = 1'b1;
    stream_frame(100, -1, 5000);
    check("restart_addr", 32'(addr), 32'd0);
    stream_frame(100, -1, -1);
    @(negedge clk);
    check("end_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
